// File: rtl/memory_pkg.sv
// Shared constants and state encoding for the row-memory scan blocks
// (memory_writer and memory_reader use the same width defaults).
package memory_pkg;

  localparam int unsigned MEM_WORD_WIDTH = 512;
  localparam int unsigned MEM_NUM_ROWS   = 128;
  localparam int unsigned MEM_BEAT_WIDTH = 64;
  localparam int unsigned MEM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    DONE    = 2'd3
  } writer_state_t;

endpackage : memory_pkg

// File: rtl/memory_writer_beat_assembler.sv
// beat_assembler: beat counter plus assembly register. Beat k lands in
// slice [k*BEAT_WIDTH +: BEAT_WIDTH]; o_done pulses on the cycle the
// final beat is accepted, and o_row_next already includes that beat.
module beat_assembler
  import memory_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = MEM_WORD_WIDTH,
  parameter int unsigned BEAT_WIDTH = MEM_BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clear,
  input  logic                  i_accept,
  input  logic [BEAT_WIDTH-1:0] i_beat,
  output logic [WORD_WIDTH-1:0] o_row_next,
  output logic                  o_done
);

  localparam int unsigned BEATS = WORD_WIDTH / BEAT_WIDTH;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [CNT_W-1:0]      r_cnt;
  logic [WORD_WIDTH-1:0] r_row;
  logic [WORD_WIDTH-1:0] w_row_next;

  // Merge the incoming beat into its slice of the row being assembled
  always_comb begin
    w_row_next = r_row;
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (i_accept && (r_cnt == CNT_W'(b))) begin
        w_row_next[b*BEAT_WIDTH +: BEAT_WIDTH] = i_beat;
      end
    end
  end

  assign o_row_next = w_row_next;
  assign o_done     = i_accept && (r_cnt == CNT_W'(BEATS - 1));

  // Beat counter and assembly register; clear discards any partial row
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_row <= '0;
    end else if (i_accept) begin
      r_cnt <= (r_cnt == CNT_W'(BEATS - 1)) ? '0 : r_cnt + CNT_W'(1);
      r_row <= w_row_next;
    end
  end

endmodule : beat_assembler

// File: rtl/memory_writer.sv
// memory_writer: collects BEATS narrow beats into one WORD_WIDTH row and
// issues a single write strobe to the shared row memory, using the
// scan_en / row_counter_in / scan_done level handshake.
// Optional feature: define MEMORY_WRITER_CHECKSUM_EN to add row_checksum,
// the 16-bit lane sum of the written row.
module memory_writer
  import memory_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = MEM_WORD_WIDTH,
  parameter int unsigned NUM_ROWS   = MEM_NUM_ROWS,
  parameter int unsigned BEAT_WIDTH = MEM_BEAT_WIDTH,
  parameter int unsigned ADDR_WIDTH = MEM_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scan_en,
  input  logic [ADDR_WIDTH-1:0] row_counter_in,
  input  logic [BEAT_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic                  scan_done,
`ifdef MEMORY_WRITER_CHECKSUM_EN
  output logic [15:0]           row_checksum,
`endif
  output logic                  scan_err
);

  localparam logic [ADDR_WIDTH:0] ROW_LIMIT = (ADDR_WIDTH + 1)'(NUM_ROWS);

  writer_state_t         r_state;
  writer_state_t         w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [WORD_WIDTH-1:0] r_wdata;
  logic                  r_err;

  logic                  w_in_range;
  logic                  w_start;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_clear;
  logic [WORD_WIDTH-1:0] w_row_next;

  assign w_in_range = ({1'b0, row_counter_in} < ROW_LIMIT);
  assign w_start    = (r_state == IDLE) && scan_en;
  assign w_accept   = (r_state == COLLECT) && data_valid;
  // Leaving for IDLE (abort or end of transaction) drops any partial row
  assign w_clear    = (w_state_next == IDLE) && (r_state != IDLE);

  beat_assembler #(
    .WORD_WIDTH (WORD_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_beat_assembler (
    .clk        (clock),
    .rst_n      (reset),
    .i_clear    (w_clear),
    .i_accept   (w_accept),
    .i_beat     (data_in),
    .o_row_next (w_row_next),
    .o_done     (w_last)
  );

  // Next-state logic; abort in COLLECT takes priority over the last beat
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (scan_en) begin
          w_state_next = w_in_range ? COLLECT : DONE;
        end
      end
      COLLECT: begin
        if (!scan_en) begin
          w_state_next = IDLE;
        end else if (w_last) begin
          w_state_next = WRITE;
        end
      end
      WRITE:   w_state_next = DONE;
      DONE: begin
        if (!scan_en) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Address latch, assembled-row capture and range-error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr <= row_counter_in;
        r_err  <= !w_in_range;
      end else if (w_clear) begin
        r_err  <= 1'b0;
      end
      if (w_last && scan_en) begin
        r_wdata <= w_row_next;
      end
    end
  end

  assign data_ready = (r_state == COLLECT);
  assign mem_we     = (r_state == WRITE);
  assign scan_done  = (r_state == DONE);
  assign scan_err   = r_err;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;

`ifdef MEMORY_WRITER_CHECKSUM_EN
  localparam int unsigned LANES = BEAT_WIDTH / 16;

  logic [15:0] r_csum;
  logic [15:0] w_beat_sum;

  // Sum of the 16-bit lanes of the current beat, modulo 2^16
  always_comb begin
    w_beat_sum = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_beat_sum = w_beat_sum + data_in[l*16 +: 16];
    end
  end

  // Running checksum, built beat by beat and cleared on return to IDLE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_csum <= '0;
    end else if (w_clear) begin
      r_csum <= '0;
    end else if (w_accept) begin
      r_csum <= r_csum + w_beat_sum;
    end
  end

  assign row_checksum = r_csum;
`endif

endmodule : memory_writer

// File: tb/tb_memory_writer.sv
// Scoreboard bench for memory_writer: stimulus pushes the expected write
// and completion records; a monitor pops them on mem_we / scan_done.
module tb_memory_writer;

  logic         clock;
  logic         reset;
  logic         scan_en;
  logic [7:0]   row_counter_in;
  logic [63:0]  data_in;
  logic         data_valid;
  logic         data_ready;
  logic         mem_we;
  logic [7:0]   mem_addr;
  logic [511:0] mem_wdata;
  logic         scan_done;
  logic         scan_err;
`ifdef MEMORY_WRITER_CHECKSUM_EN
  logic [15:0]  row_checksum;
`endif

  memory_writer #(
    .WORD_WIDTH (512),
    .NUM_ROWS   (128),
    .BEAT_WIDTH (64),
    .ADDR_WIDTH (8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .scan_en        (scan_en),
    .row_counter_in (row_counter_in),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .scan_done      (scan_done),
`ifdef MEMORY_WRITER_CHECKSUM_EN
    .row_checksum   (row_checksum),
`endif
    .scan_err       (scan_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]   addr;
    logic [511:0] data;
  } wr_t;

  wr_t  sb_wr[$];
  logic sb_done[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: compare every write strobe and every scan_done rise
  initial begin
    logic prev_done;
    wr_t  e;
    logic e_err;
    prev_done = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_we === 1'b1) begin
        if (sb_wr.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_we: got addr %0d expected no write", mem_addr);
        end else begin
          e = sb_wr.pop_front();
          chk("we_addr", mem_addr, e.addr);
          chk("we_data", mem_wdata, e.data);
        end
      end
      if (scan_done === 1'b1 && !prev_done) begin
        if (sb_done.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_done: got scan_done=1 expected 0");
        end else begin
          e_err = sb_done.pop_front();
          chk("done_err", scan_err, e_err);
        end
      end
      prev_done = (scan_done === 1'b1);
    end
  end

  // Full in-range transaction with 0..gap_max idle cycles before each beat
  task automatic do_row(input logic [7:0] row, input logic [511:0] word, input int unsigned gap_max);
    int unsigned g;
    sb_wr.push_back('{addr: row, data: word});
    sb_done.push_back(1'b0);
    scan_en        = 1'b1;
    row_counter_in = row;
    tick();
    chk("ready_rise", data_ready, 1);
    for (int b = 0; b < 8; b++) begin
      g = $urandom_range(0, gap_max);
      data_valid = 1'b0;
      repeat (g) tick();
      data_valid = 1'b1;
      data_in    = word[b*64 +: 64];
      tick();
    end
    data_valid = 1'b0;
    chk("we_timing", mem_we, 1);
    tick();
    chk("done_timing", scan_done, 1);
    chk("ready_in_done", data_ready, 0);
    scan_en = 1'b0;
    tick();
    chk("done_drop", scan_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [511:0] w;

    // Reset held low with scan_en already requesting
    reset          = 1'b0;
    scan_en        = 1'b1;
    row_counter_in = 8'd5;
    data_in        = '0;
    data_valid     = 1'b0;
    tick();
    tick();
    chk("rst_ready", data_ready, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_err", scan_err, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    reset = 1'b1;
    chk("ready_pre_edge", data_ready, 0);
    tick();
    chk("ready_after_rst", data_ready, 1);
    scan_en = 1'b0;
    tick();
    chk("ready_after_abort", data_ready, 0);

    // Basic write: row 5, beat i carries value i, no gaps
    for (int b = 0; b < 8; b++) w[b*64 +: 64] = 64'(b);
    do_row(8'd5, w, 0);
    chk("addr_hold", mem_addr, 5);
    chk("wdata_hold", mem_wdata, w);

    // Abort after 3 beats: nothing written, no completion
    scan_en        = 1'b1;
    row_counter_in = 8'd3;
    tick();
    for (int b = 0; b < 3; b++) begin
      data_valid = 1'b1;
      data_in    = 64'hDEAD_BEEF_0000_0000 | 64'(b);
      tick();
    end
    data_valid = 1'b0;
    scan_en    = 1'b0;
    tick();
    chk("abort_ready", data_ready, 0);
    chk("abort_done", scan_done, 0);
    chk("abort_we", mem_we, 0);

    // Clean row 9 after the abort: a leftover beat count would misplace beats
    for (int b = 0; b < 8; b++) w[b*64 +: 64] = {32'h9999_0000, 32'(b + 1)};
    do_row(8'd9, w, 0);

    // Out-of-range row
    sb_done.push_back(1'b1);
    scan_en        = 1'b1;
    row_counter_in = 8'd200;
    tick();
    chk("oor_done", scan_done, 1);
    chk("oor_err", scan_err, 1);
    chk("oor_ready", data_ready, 0);
    chk("oor_addr", mem_addr, 200);
    data_valid = 1'b1;
    data_in    = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    chk("oor_ready_hold", data_ready, 0);
    chk("oor_done_hold", scan_done, 1);
`ifdef MEMORY_WRITER_CHECKSUM_EN
    chk("oor_csum", row_checksum, 0);
`endif
    data_valid = 1'b0;
    scan_en    = 1'b0;
    tick();
    chk("oor_done_clear", scan_done, 0);
    chk("oor_err_clear", scan_err, 0);

    // Sweep every row with 0..3 idle cycles between beats
    for (int r = 0; r < 128; r++) begin
      for (int b = 0; b < 8; b++) begin
        w[b*64 +: 64] = {24'hC0FFEE, 8'(r), 24'h000000, 8'(b)};
      end
      do_row(8'(r), w, 3);
    end

`ifdef MEMORY_WRITER_CHECKSUM_EN
    // 32 lanes of 16'h0001 sum to 16'h0020; check while scan_done holds
    w = {32{16'h0001}};
    sb_wr.push_back('{addr: 8'd11, data: w});
    sb_done.push_back(1'b0);
    scan_en        = 1'b1;
    row_counter_in = 8'd11;
    tick();
    for (int b = 0; b < 8; b++) begin
      data_valid = 1'b1;
      data_in    = w[b*64 +: 64];
      tick();
    end
    data_valid = 1'b0;
    tick();
    chk("csum_done", scan_done, 1);
    chk("csum_value", row_checksum, 16'h0020);
    scan_en = 1'b0;
    tick();

    // Reset mid-COLLECT: no write, checksum cleared
    scan_en        = 1'b1;
    row_counter_in = 8'd12;
    tick();
    for (int b = 0; b < 2; b++) begin
      data_valid = 1'b1;
      data_in    = 64'h0003_0003_0003_0003;
      tick();
    end
    data_valid = 1'b0;
    reset      = 1'b0;
    scan_en    = 1'b0;
    tick();
    chk("csum_rst", row_checksum, 0);
    chk("csum_rst_we", mem_we, 0);
    chk("csum_rst_ready", data_ready, 0);
    reset = 1'b1;
    tick();
`endif

    repeat (4) tick();
    chk("sb_wr_empty", sb_wr.size(), 0);
    chk("sb_done_empty", sb_done.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_memory_writer
